// File: rtl/siso_tx_sched_pkg.sv
// Shared definitions for the serial-lane scheduler.
//   state_t   : scheduler FSM states (idle, shifting a frame, inter-frame gap)
//   DEF_WIDTH : default frame width in bits
//   req_id_t  : requester index (two requesters)
//   onehot()  : requester index -> one-hot accept vector
package siso_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP} state_t;

  localparam int DEF_WIDTH = 4;

  typedef logic req_id_t;

  function automatic logic [1:0] onehot(input req_id_t id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/siso_tx_sched_if.sv
// Bundle of the scheduler's requester handshake and serial output lane.
//   req_valid/req_data0/req_data1 : requester words and their valid flags
//   req_ready                     : one-hot accept back to the requesters
//   so/so_en/so_sof/so_eof        : serial bit, bit-valid, frame start/end strobes
//   grant_id/busy                 : owner of current/last frame, scheduler active
// master = requesters and serial sink, slave = scheduler.
interface siso_tx_sched_if import siso_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) ();

  logic [1:0]       req_valid;
  logic [WIDTH-1:0] req_data0;
  logic [WIDTH-1:0] req_data1;
  logic [1:0]       req_ready;
  logic             so;
  logic             so_en;
  logic             so_sof;
  logic             so_eof;
  req_id_t          grant_id;
  logic             busy;

  modport master (
    output req_valid, req_data0, req_data1,
    input  req_ready, so, so_en, so_sof, so_eof, grant_id, busy
  );

  modport slave (
    input  req_valid, req_data0, req_data1,
    output req_ready, so, so_en, so_sof, so_eof, grant_id, busy
  );

endinterface

// File: rtl/siso_tx_sched_shift_reg.sv
// WIDTH-bit right-shifting register with parallel load; zero-fills the MSB so
// the serial output returns to 0 once a word has been fully shifted out.
//   clk, rst (async, active-low)
//   load    : capture data_in (wins over shift)
//   shift   : shift right by one
//   data_in : parallel word
//   so      : serial out, sr[0]
module siso_shift_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] data_in,
  output logic             so
);

  logic [WIDTH-1:0] sr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr <= '0;
    end else if (load) begin
      sr <= data_in;
    end else if (shift) begin
      sr <= {1'b0, sr[WIDTH-1:1]};
    end
  end

  assign so = sr[0];

endmodule

// File: rtl/siso_tx_sched.sv
// Round-robin scheduler sharing one serial shift path between two requesters.
// In IDLE it accepts one word (combinational one-hot req_ready), then shifts it
// out LSB-first with so_en/so_sof/so_eof strobes, then idles GAP cycles.
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : siso_tx_sched_if.slave (requester handshake + serial lane)
module siso_tx_sched import siso_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int GAP   = 1
) (
  input logic            clk,
  input logic            rst,
  siso_tx_sched_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_PEN  = CW'(WIDTH - 2);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [GW-1:0]    gcnt;
  req_id_t          rr;
  req_id_t          win;
  req_id_t          grant_r;
  logic [1:0]       ready;
  logic             hs;
  logic [WIDTH-1:0] word;
  logic             so_en_r;
  logic             so_sof_r;
  logic             so_eof_r;
  logic             busy_r;
  logic             sr_so;

  // Arbitration: rr breaks ties, a lone valid wins outright. Gated by rst so
  // nothing is accepted while reset is held.
  always_comb begin
    win = 1'b0;
    if (&bus.req_valid) begin
      win = rr;
    end else if (bus.req_valid[1]) begin
      win = 1'b1;
    end
    ready = 2'b00;
    if (rst && (state == ST_IDLE) && (|bus.req_valid)) begin
      ready = onehot(win);
    end
  end

  assign hs   = |(bus.req_valid & ready);
  assign word = win ? bus.req_data1 : bus.req_data0;

  // Shift register is loaded on the accepting edge, so sr[0] already carries
  // bit 0 in the first SHIFT cycle; WIDTH shifts leave it all-zero afterwards.
  siso_shift_reg #(.WIDTH(WIDTH)) u_sr (
    .clk     (clk),
    .rst     (rst),
    .load    (hs),
    .shift   (state == ST_SHIFT),
    .data_in (word),
    .so      (sr_so)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      gcnt     <= '0;
      rr       <= 1'b0;
      grant_r  <= 1'b0;
      so_en_r  <= 1'b0;
      so_sof_r <= 1'b0;
      so_eof_r <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (hs) begin
            state    <= ST_SHIFT;
            cnt      <= '0;
            grant_r  <= win;
            rr       <= ~win;
            so_en_r  <= 1'b1;
            so_sof_r <= 1'b1;
            so_eof_r <= 1'b0;
            busy_r   <= 1'b1;
          end
        end
        ST_SHIFT: begin
          so_sof_r <= 1'b0;
          if (cnt == CNT_LAST) begin
            so_en_r  <= 1'b0;
            so_eof_r <= 1'b0;
            gcnt     <= '0;
            if (GAP > 0) begin
              state <= ST_GAP;
            end else begin
              state  <= ST_IDLE;
              busy_r <= 1'b0;
            end
          end else begin
            cnt      <= cnt + 1'b1;
            // eof is raised one edge early so it lines up with the last bit.
            so_eof_r <= (cnt == CNT_PEN);
          end
        end
        ST_GAP: begin
          if (gcnt == GAP_LAST) begin
            state  <= ST_IDLE;
            busy_r <= 1'b0;
          end else begin
            gcnt <= gcnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready = ready;
  assign bus.so        = sr_so;
  assign bus.so_en     = so_en_r;
  assign bus.so_sof    = so_sof_r;
  assign bus.so_eof    = so_eof_r;
  assign bus.grant_id  = grant_r;
  assign bus.busy      = busy_r;

endmodule
